// File: rtl/ascon_pkg.sv
// Shared definitions for the ASCON text sequencer: FSM state encoding, rate geometry
// and mode codes, plus the per-beat byte-count helper.
package ascon_pkg;

  localparam int unsigned ASCON_RATE_BYTES = 16;
  localparam int unsigned ASCON_RATE_BITS  = 128;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    CAPT,
    EMIT,
    FIN
  } seq_state_e;

  // Bytes carried by a beat: a full rate block, or whatever is left of the text.
  function automatic logic [4:0] beat_bytes(input logic [31:0] remaining);
    if (remaining >= 32'(ASCON_RATE_BYTES)) return 5'(ASCON_RATE_BYTES);
    return remaining[4:0];
  endfunction

endpackage

// File: rtl/ascon_seq_outbuf.sv
// Single-entry output register for the sequencer: holds data, byte count and last flag
// stable from load until the downstream handshake.
module ascon_seq_outbuf
  import ascon_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [ASCON_RATE_BITS-1:0] load_data,
  input  logic [4:0]                 load_bytes,
  input  logic                       load_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ASCON_RATE_BITS-1:0] out_data,
  output logic [4:0]                 out_bytes,
  output logic                       out_last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload register is reset as well so out_data reads 0 from reset.
      out_valid <= 1'b0;
      out_data  <= '0;
      out_bytes <= '0;
      out_last  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      if (load && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
        out_bytes <= load_bytes;
        out_last  <= load_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ascon_text_sequencer.sv
// ASCON text sequencer: steps the encrypt/decrypt datapath through a text stream one rate
// block at a time. Defining ASCON_SEQ_PERF_EN adds blk_count / stall_cycles counters.
module ascon_text_sequencer
  import ascon_pkg::*;
#(
  parameter logic [31:0] MAX_TEXT_LEN = 32'h0010_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       mode_sel,
  input  logic [31:0]                text_length,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ASCON_RATE_BITS-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ASCON_RATE_BITS-1:0] out_data,
  output logic [4:0]                 out_bytes,
  output logic                       out_last,
  output logic                       dp_process_en,
  output logic                       dp_mode_sel,
  output logic [31:0]                dp_text_length,
  output logic [31:0]                dp_text_position,
  output logic [ASCON_RATE_BITS-1:0] dp_data_in,
  input  logic [ASCON_RATE_BITS-1:0] dp_data_out,
  input  logic                       dp_process_err
`ifdef ASCON_SEQ_PERF_EN
  ,
  output logic [31:0]                blk_count,
  output logic [31:0]                stall_cycles
`endif
);

  seq_state_e                 state_q, state_d;
  logic                       mode_q, err_q, done_q;
  logic [31:0]                length_q, position_q, remaining;
  logic [ASCON_RATE_BITS-1:0] data_in_q;
  logic                       rem_zero, rem_last, more_blocks;
  logic                       start_accept, start_reject, out_hs;

  assign remaining    = length_q - position_q;
  assign rem_zero     = (remaining == 32'd0);
  assign rem_last     = (remaining <= 32'(ASCON_RATE_BYTES));
  // A final block that exactly fills the rate still owes the padding-only block.
  assign more_blocks  = (remaining >= 32'(ASCON_RATE_BYTES));
  assign start_accept = (state_q == IDLE) && start && (text_length <= MAX_TEXT_LEN);
  assign start_reject = (state_q == IDLE) && start && (text_length > MAX_TEXT_LEN);
  assign out_hs       = out_valid && out_ready;

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_accept) state_d = FETCH;
      FETCH:   if (rem_zero || in_valid) state_d = EXEC;
      EXEC:    state_d = dp_process_err ? FIN : CAPT;
      CAPT:    state_d = rem_zero ? FIN : EMIT;
      EMIT:    if (out_hs) state_d = more_blocks ? FETCH : FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= MODE_ENC;
      length_q   <= '0;
      position_q <= '0;
      data_in_q  <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == FIN) || start_reject;
      if (start_reject) err_q <= 1'b1;
      if (start_accept) begin
        mode_q     <= mode_sel;
        length_q   <= text_length;
        position_q <= '0;
        err_q      <= 1'b0;
      end
      if (state_q == FETCH) begin
        if (rem_zero) data_in_q <= '0;
        else if (in_valid) data_in_q <= in_data;
      end
      if ((state_q == EXEC) && dp_process_err) err_q <= 1'b1;
      if ((state_q == EMIT) && out_hs && more_blocks)
        position_q <= position_q + 32'(ASCON_RATE_BYTES);
    end
  end

  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign err              = err_q;
  assign in_ready         = (state_q == FETCH) && !rem_zero;
  assign dp_process_en    = (state_q == EXEC);
  assign dp_mode_sel      = mode_q;
  assign dp_text_length   = length_q;
  assign dp_text_position = position_q;
  assign dp_data_in       = data_in_q;

  // The padding-only block updates the state but produces no output beat.
  ascon_seq_outbuf u_outbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       ((state_q == CAPT) && !rem_zero),
    .load_data  (dp_data_out),
    .load_bytes (beat_bytes(remaining)),
    .load_last  (rem_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_bytes  (out_bytes),
    .out_last   (out_last)
  );

`ifdef ASCON_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_count    <= '0;
      stall_cycles <= '0;
    end else begin
      if (start_accept) blk_count <= '0;
      else if (dp_process_en && (blk_count != '1)) blk_count <= blk_count + 32'd1;
      if ((((state_q == FETCH) && !in_valid) || ((state_q == EMIT) && !out_ready)) &&
          (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ascon_text_sequencer.sv
// Self-checking bench for ascon_text_sequencer: directed commands with random text data,
// checked against a block/beat stream model derived from the text length.
module tb_ascon_text_sequencer;
  import ascon_pkg::*;

  localparam logic [31:0] MAX_LEN = 32'h0010_0000;

  logic         clk = 1'b0;
  logic         rst_n, start, mode_sel;
  logic [31:0]  text_length;
  logic         busy, done, err;
  logic         in_valid, in_ready;
  logic [127:0] in_data;
  logic         out_valid, out_ready, out_last;
  logic [127:0] out_data;
  logic [4:0]   out_bytes;
  logic         dp_process_en, dp_mode_sel;
  logic [31:0]  dp_text_length, dp_text_position;
  logic [127:0] dp_data_in, dp_data_out;
  logic         dp_process_err;
  logic         err_inject = 1'b0;
  logic [31:0]  err_pos = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ascon_text_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .mode_sel         (mode_sel),
    .text_length      (text_length),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_bytes        (out_bytes),
    .out_last         (out_last),
    .dp_process_en    (dp_process_en),
    .dp_mode_sel      (dp_mode_sel),
    .dp_text_length   (dp_text_length),
    .dp_text_position (dp_text_position),
    .dp_data_in       (dp_data_in),
    .dp_data_out      (dp_data_out),
    .dp_process_err   (dp_process_err)
  );

  // Stand-in datapath: a position/mode dependent scramble of the block it was handed.
  function automatic logic [127:0] dp_model(input logic [127:0] d, input logic [31:0] pos,
                                            input logic m);
    return d ^ {pos, ~pos, pos ^ 32'hA5A5_5A5A, {32{m}}};
  endfunction

  assign dp_data_out    = dp_model(dp_data_in, dp_text_position, dp_mode_sel);
  assign dp_process_err = err_inject && dp_process_en && (dp_text_position == err_pos);

  // Observation log, sampled on the falling edge.
  int           cyc = 0;
  int           done_cnt = 0, in_ready_cnt = 0, out_valid_cnt = 0, overlap_cnt = 0, hold_viol = 0;
  logic [31:0]  inv_pos[$];
  logic [127:0] inv_din[$];
  logic         inv_mode[$];
  logic [31:0]  inv_len[$];
  int           inv_cyc[$];
  logic [127:0] beat_data[$];
  logic [4:0]   beat_nb[$];
  logic         beat_last[$];
  int           beat_cyc[$];
  int           in_hs_cyc[$];
  int           ov_rise_cyc[$];
  logic         prev_ov = 1'b0, held = 1'b0, held_last = 1'b0;
  logic [127:0] held_data = '0;
  logic [4:0]   held_bytes = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (dp_process_en) begin
      inv_pos.push_back(dp_text_position);
      inv_din.push_back(dp_data_in);
      inv_mode.push_back(dp_mode_sel);
      inv_len.push_back(dp_text_length);
      inv_cyc.push_back(cyc);
    end
    if (in_valid && in_ready) in_hs_cyc.push_back(cyc);
    if (out_valid && !prev_ov) ov_rise_cyc.push_back(cyc);
    if (out_valid && out_ready) begin
      beat_data.push_back(out_data);
      beat_nb.push_back(out_bytes);
      beat_last.push_back(out_last);
      beat_cyc.push_back(cyc);
    end
    if (held && out_valid &&
        (out_data !== held_data || out_bytes !== held_bytes || out_last !== held_last))
      hold_viol = hold_viol + 1;
    if (done) done_cnt = done_cnt + 1;
    if (in_ready) in_ready_cnt = in_ready_cnt + 1;
    if (out_valid) out_valid_cnt = out_valid_cnt + 1;
    if (out_valid && in_ready) overlap_cnt = overlap_cnt + 1;
    held       = out_valid && !out_ready;
    held_data  = out_data;
    held_bytes = out_bytes;
    held_last  = out_last;
    prev_ov    = out_valid;
  end

  logic [127:0] sent[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input logic m, input logic [31:0] len);
    mode_sel    = m;
    text_length = len;
    start       = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int gap);
    bit hs;
    int budget;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, gap)) tick();
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      hs       = 1'b0;
      budget   = 0;
      while (!hs && budget < 400) begin
        @(negedge clk);
        hs = in_ready;
        tick();
        budget++;
      end
      in_valid = 1'b0;
      sent.push_back(in_data);
      check("feed_accepted", 128'(hs), 128'(1));
    end
  endtask

  task automatic consume(input int n, input int stall);
    int got, left, budget;
    got = 0; left = stall; budget = 0;
    while (got < n && budget < 800) begin
      out_ready = (left == 0);
      @(negedge clk);
      if (out_valid) begin
        if (out_ready) begin
          got++;
          left = stall;
        end else begin
          left--;
        end
      end
      tick();
      budget++;
    end
    out_ready = 1'b0;
    check("consume_all", 128'(got), 128'(n));
  endtask

  task automatic poke_start(input logic m);
    repeat (3) tick();
    mode_sel    = m;
    text_length = 32'd5;
    start       = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_cmd(input logic m, input logic [31:0] len, input int stall, input int gap,
                         input bit poke, input bit inj, input logic [31:0] epos);
    int n_inv, n_in, n_out, wait_cnt;
    int b_inv, b_beat, b_done, b_inr, b_ovc, b_ovr, b_inhs, b_hold, b_lap;
    logic [31:0]  p, rem;
    logic [127:0] exp_din;
    logic [4:0]   exp_nb;
    // Model: one block per 16-byte position 0..16*floor(L/16); error stops after its block.
    n_inv = 0; n_in = 0; n_out = 0;
    for (int k = 0; k <= int'(len >> 4); k++) begin
      p = 32'(k) << 4;
      n_inv++;
      if (p < len) n_in++;
      if (inj && p == epos) break;
      if (p < len) n_out++;
    end
    sent.delete();
    b_inv = inv_pos.size(); b_beat = beat_data.size(); b_done = done_cnt;
    b_inr = in_ready_cnt; b_ovc = out_valid_cnt; b_ovr = ov_rise_cyc.size();
    b_inhs = in_hs_cyc.size(); b_hold = hold_viol; b_lap = overlap_cnt;
    err_inject = inj;
    err_pos    = epos;
    issue_start(m, len);
    check("err_clear", 128'(err), 128'(0));
    check("busy_on", 128'(busy), 128'(1));
    fork
      feed(n_in, gap);
      consume(n_out, stall);
      if (poke) poke_start(~m);
    join
    wait_cnt = 0;
    while (done_cnt == b_done && wait_cnt < 300) begin
      tick();
      wait_cnt++;
    end
    repeat (3) tick();
    err_inject = 1'b0;

    check("done_pulses", 128'(done_cnt - b_done), 128'(1));
    check("err_final", 128'(err), 128'(inj));
    check("busy_off", 128'(busy), 128'(0));
    check("inv_count", 128'(inv_pos.size() - b_inv), 128'(n_inv));
    for (int k = 0; k < n_inv && b_inv + k < inv_pos.size(); k++) begin
      p = 32'(k) << 4;
      exp_din = (p < len && k < sent.size()) ? sent[k] : '0;
      check($sformatf("inv%0d_pos", k), 128'(inv_pos[b_inv+k]), 128'(p));
      check($sformatf("inv%0d_din", k), inv_din[b_inv+k], exp_din);
      check($sformatf("inv%0d_mode", k), 128'(inv_mode[b_inv+k]), 128'(m));
      check($sformatf("inv%0d_len", k), 128'(inv_len[b_inv+k]), 128'(len));
    end
    check("beat_count", 128'(beat_data.size() - b_beat), 128'(n_out));
    for (int k = 0; k < n_out && b_beat + k < beat_data.size() && k < sent.size(); k++) begin
      p      = 32'(k) << 4;
      rem    = len - p;
      exp_nb = (rem >= 32'd16) ? 5'd16 : rem[4:0];
      check($sformatf("beat%0d_data", k), beat_data[b_beat+k], dp_model(sent[k], p, m));
      check($sformatf("beat%0d_bytes", k), 128'(beat_nb[b_beat+k]), 128'(exp_nb));
      check($sformatf("beat%0d_last", k), 128'(beat_last[b_beat+k]), 128'(rem <= 32'd16));
    end
    check("out_hold_stable", 128'(hold_viol - b_hold), 128'(0));
    check("no_fetch_while_emit", 128'(overlap_cnt - b_lap), 128'(0));
    if (n_in == 0) begin
      check("no_in_ready", 128'(in_ready_cnt - b_inr), 128'(0));
      check("no_out_valid", 128'(out_valid_cnt - b_ovc), 128'(0));
    end
    if (n_out > 0 && b_ovr < ov_rise_cyc.size() && b_inhs < in_hs_cyc.size())
      check("in_to_out_latency", 128'(ov_rise_cyc[b_ovr] - in_hs_cyc[b_inhs]), 128'(3));
    if (n_inv > 1 && n_out > 0 && b_inv + 1 < inv_cyc.size() && b_beat < beat_cyc.size())
      check("strobe_after_handshake", 128'(inv_cyc[b_inv+1] > beat_cyc[b_beat]), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b_done, b_inv, budget;
    rst_n = 1'b0; start = 1'b0; mode_sel = 1'b0; text_length = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_flags", 128'({done, err, in_ready, out_valid, out_last, dp_process_en, dp_mode_sel}),
          128'(0));
    check("rst_dp_regs", 128'({dp_text_length, dp_text_position}), 128'(0));
    check("rst_data", dp_data_in | out_data | 128'(out_bytes), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed streams from the test plan.
    run_cmd(MODE_ENC, 32'd40, 0, 0, 1'b0, 1'b0, '0);
    run_cmd(MODE_ENC, 32'd32, 0, 0, 1'b0, 1'b0, '0);
    run_cmd(MODE_DEC, 32'd0, 0, 0, 1'b0, 1'b0, '0);
    run_cmd(MODE_ENC, 32'd40, 5, 0, 1'b1, 1'b0, '0);

    // Length reject, then a legal start clears err.
    b_done = done_cnt;
    b_inv  = inv_pos.size();
    issue_start(MODE_ENC, MAX_LEN + 32'd1);
    repeat (3) tick();
    check("reject_err", 128'(err), 128'(1));
    check("reject_done", 128'(done_cnt - b_done), 128'(1));
    check("reject_no_strobe", 128'(inv_pos.size() - b_inv), 128'(0));
    check("reject_idle", 128'(busy), 128'(0));
    run_cmd(MODE_DEC, 32'd20, 1, 1, 1'b0, 1'b0, '0);

    // Datapath error on the second block aborts the stream.
    run_cmd(MODE_ENC, 32'd48, 0, 0, 1'b0, 1'b1, 32'd16);

    // Random lengths, modes, input gaps and output stalls.
    for (int i = 0; i < 6; i++)
      run_cmd(1'($urandom_range(0, 1)), 32'($urandom_range(1, 70)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0, 1'b0, '0);
    run_cmd(MODE_DEC, MAX_LEN - 32'd16 + 32'd16 - MAX_LEN + 32'd64, 2, 0, 1'b0, 1'b0, '0);

    // Asynchronous reset while the first beat of a 48-byte stream is stalled in EMIT.
    issue_start(MODE_ENC, 32'd48);
    feed(1, 0);
    budget = 0;
    while (!out_valid && budget < 50) begin
      tick();
      budget++;
    end
    check("emit_reached", 128'(out_valid), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'(0));
    check("arst_busy", 128'(busy), 128'(0));
    check("arst_strobe", 128'(dp_process_en), 128'(0));
    check("arst_position", 128'(dp_text_position), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_cmd(MODE_ENC, 32'd16, 1, 0, 1'b0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
